pipe_datapath: RTL and testbench

- Parametrised, two-stage pipelined successor of the single-cycle register-file/function-unit datapath.
- Generalised in data width and register count; adds operand forwarding, a pipeline hold, valid/bubble tracking and a flag-load control bit.
- Sits between the control unit, which issues one control word per cycle, and the memory port.
- Memory sees address/data from the operand stage; read data returns one cycle later into the execute/writeback stage.

---
 rtl/pipe_dp_pkg.sv | 50 +++++
 rtl/pipe_datapath_if.sv | 34 +++
 rtl/pipe_alu.sv | 78 +++++++
 rtl/pipe_datapath.sv | 152 +++++++++++++++
 tb/tb_pipe_datapath.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_dp_pkg.sv
// Shared definitions for the two-stage pipelined datapath: ALU opcodes,
// control-word field positions and the stage-2 control record.
package pipe_dp_pkg;

    localparam logic [3:0] FS_PASSA  = 4'b0000;
    localparam logic [3:0] FS_INC    = 4'b0001;
    localparam logic [3:0] FS_ADD    = 4'b0010;
    localparam logic [3:0] FS_ADDC   = 4'b0011;
    localparam logic [3:0] FS_ADDNB  = 4'b0100;
    localparam logic [3:0] FS_SUB    = 4'b0101;
    localparam logic [3:0] FS_DEC    = 4'b0110;
    localparam logic [3:0] FS_PASSA2 = 4'b0111;
    localparam logic [3:0] FS_AND    = 4'b1000;
    localparam logic [3:0] FS_OR     = 4'b1001;
    localparam logic [3:0] FS_XOR    = 4'b1010;
    localparam logic [3:0] FS_NOTA   = 4'b1011;
    localparam logic [3:0] FS_PASSB  = 4'b1100;
    localparam logic [3:0] FS_SHR    = 4'b1101;
    localparam logic [3:0] FS_SHL    = 4'b1110;
    localparam logic [3:0] FS_ZERO   = 4'b1111;

    // Control word layout, LSB upward: FL, RW, MD, FS[3:0], MB, BA, AA, DA
    localparam int CW_FL_BIT = 0;
    localparam int CW_RW_BIT = 1;
    localparam int CW_MD_BIT = 2;
    localparam int CW_FS_LSB = 3;
    localparam int CW_MB_BIT = 7;
    localparam int CW_BA_LSB = 8;

    function automatic int cwAaLsb(input int aw);
        return CW_BA_LSB + aw;
    endfunction

    function automatic int cwDaLsb(input int aw);
        return CW_BA_LSB + 2 * aw;
    endfunction

    function automatic int cwWidth(input int aw);
        return CW_BA_LSB + 3 * aw;
    endfunction

    typedef struct packed {
        logic       valid;
        logic [3:0] fs;
        logic       md;
        logic       rw;
        logic       fl;
    } s2_ctrl_t;

endpackage

// File: rtl/pipe_datapath_if.sv
// Control-unit / memory-side bundle of the pipelined datapath.
interface pipe_datapath_if
    import pipe_dp_pkg::*;
#(
    parameter int W    = 16,
    parameter int NREG = 8
);
    localparam int AW = $clog2(NREG);

    logic                    VIN;
    logic                    HOLD;
    logic [cwWidth(AW)-1:0]  CTRWRD;
    logic [W-1:0]            Cin;
    logic [W-1:0]            Din;
    logic [W-1:0]            Adrout;
    logic [W-1:0]            Dout;
    logic                    V;
    logic                    C;
    logic                    N;
    logic                    Z;
    logic                    WB_VALID;
    logic [W-1:0]            WB_DATA;

    modport master (
        output VIN, HOLD, CTRWRD, Cin, Din,
        input  Adrout, Dout, V, C, N, Z, WB_VALID, WB_DATA
    );

    modport slave (
        input  VIN, HOLD, CTRWRD, Cin, Din,
        output Adrout, Dout, V, C, N, Z, WB_VALID, WB_DATA
    );

endinterface

// File: rtl/pipe_alu.sv
// Combinational function unit: arithmetic, logic and single-bit shifts
// with carry/overflow/negative/zero status.
module pipe_alu
    import pipe_dp_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [3:0]   i_fs,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_f,
    output logic         o_v,
    output logic         o_c,
    output logic         o_n,
    output logic         o_z
);

    logic [W-1:0] w_addB;
    logic         w_cin;
    logic [W:0]   w_sum;
    logic         w_ovf;

    // Every arithmetic op is A + operand + carry-in, so carry and overflow come from one adder
    always_comb begin
        w_addB = '0;
        w_cin  = 1'b0;
        case (i_fs)
            FS_INC:   w_cin = 1'b1;
            FS_ADD:   w_addB = i_b;
            FS_ADDC: begin
                w_addB = i_b;
                w_cin  = 1'b1;
            end
            FS_ADDNB: w_addB = ~i_b;
            FS_SUB: begin
                w_addB = ~i_b;
                w_cin  = 1'b1;
            end
            FS_DEC:   w_addB = '1;
            default:  ;
        endcase
    end

    assign w_sum = {1'b0, i_a} + {1'b0, w_addB} + {{W{1'b0}}, w_cin};
    assign w_ovf = (i_a[W-1] == w_addB[W-1]) && (w_sum[W-1] != i_a[W-1]);

    always_comb begin
        o_f = '0;
        o_c = 1'b0;
        o_v = 1'b0;
        if (!i_fs[3]) begin
            o_f = w_sum[W-1:0];
            o_c = w_sum[W];
            o_v = w_ovf;
        end else begin
            case (i_fs)
                FS_AND:   o_f = i_a & i_b;
                FS_OR:    o_f = i_a | i_b;
                FS_XOR:   o_f = i_a ^ i_b;
                FS_NOTA:  o_f = ~i_a;
                FS_PASSB: o_f = i_b;
                FS_SHR: begin
                    o_f = {1'b0, i_b[W-1:1]};
                    o_c = i_b[0];
                end
                FS_SHL: begin
                    o_f = {i_b[W-2:0], 1'b0};
                    o_c = i_b[W-1];
                end
                default:  o_f = '0;
            endcase
        end
    end

    assign o_n = o_f[W-1];
    assign o_z = ~|o_f;

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage register-file datapath: operand fetch with forwarding, then
// execute/writeback with optional memory load and flag update.
module pipe_datapath
    import pipe_dp_pkg::*;
#(
    parameter int W       = 16,
    parameter int NREG    = 8,
    parameter int ZERO_R0 = 0
) (
    input  logic           CLK,
    input  logic           RESET,
    pipe_datapath_if.slave bus
);

    localparam int AW     = $clog2(NREG);
    localparam int AA_LSB = cwAaLsb(AW);
    localparam int DA_LSB = cwDaLsb(AW);
    localparam bit Z0     = (ZERO_R0 != 0);

    logic [W-1:0]  r_regs [NREG];
    s2_ctrl_t      r_s2;
    logic [W-1:0]  r_s2A;
    logic [W-1:0]  r_s2B;
    logic [AW-1:0] r_s2Da;
    logic          r_v;
    logic          r_c;
    logic          r_n;
    logic          r_z;

    logic [AW-1:0] w_da;
    logic [AW-1:0] w_aa;
    logic [AW-1:0] w_ba;
    logic          w_mb;
    logic [3:0]    w_fs;
    logic          w_md;
    logic          w_rw;
    logic          w_fl;
    logic          w_s2Writes;
    logic          w_fwdA;
    logic          w_fwdB;
    logic [W-1:0]  w_opA;
    logic [W-1:0]  w_regB;
    logic [W-1:0]  w_opB;
    logic [W-1:0]  w_f;
    logic          w_aluV;
    logic          w_aluC;
    logic          w_aluN;
    logic          w_aluZ;
    logic [W-1:0]  w_busD;
    logic          w_commit;

    assign w_da = bus.CTRWRD[DA_LSB +: AW];
    assign w_aa = bus.CTRWRD[AA_LSB +: AW];
    assign w_ba = bus.CTRWRD[CW_BA_LSB +: AW];
    assign w_mb = bus.CTRWRD[CW_MB_BIT];
    assign w_fs = bus.CTRWRD[CW_FS_LSB +: 4];
    assign w_md = bus.CTRWRD[CW_MD_BIT];
    assign w_rw = bus.CTRWRD[CW_RW_BIT];
    assign w_fl = bus.CTRWRD[CW_FL_BIT];

    // Stage-2 result is forwarded even while held, since the write is still pending
    assign w_s2Writes = r_s2.valid & r_s2.rw;
    assign w_fwdA     = w_s2Writes && (r_s2Da == w_aa) && !(Z0 && (w_aa == '0));
    assign w_fwdB     = w_s2Writes && (r_s2Da == w_ba) && !(Z0 && (w_ba == '0));

    always_comb begin
        w_opA = r_regs[w_aa];
        if (Z0 && (w_aa == '0)) begin
            w_opA = '0;
        end else if (w_fwdA) begin
            w_opA = w_busD;
        end
    end

    always_comb begin
        w_regB = r_regs[w_ba];
        if (Z0 && (w_ba == '0)) begin
            w_regB = '0;
        end else if (w_fwdB) begin
            w_regB = w_busD;
        end
    end

    assign w_opB = w_mb ? bus.Cin : w_regB;

    pipe_alu #(.W(W)) u_alu (
        .i_fs (r_s2.fs),
        .i_a  (r_s2A),
        .i_b  (r_s2B),
        .o_f  (w_f),
        .o_v  (w_aluV),
        .o_c  (w_aluC),
        .o_n  (w_aluN),
        .o_z  (w_aluZ)
    );

    assign w_busD   = r_s2.md ? bus.Din : w_f;
    assign w_commit = w_s2Writes & ~bus.HOLD;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s2   <= '0;
            r_s2A  <= '0;
            r_s2B  <= '0;
            r_s2Da <= '0;
        end else if (!bus.HOLD) begin
            r_s2.valid <= bus.VIN;
            r_s2.fs    <= w_fs;
            r_s2.md    <= w_md;
            r_s2.rw    <= w_rw;
            r_s2.fl    <= w_fl;
            r_s2A      <= w_opA;
            r_s2B      <= w_opB;
            r_s2Da     <= w_da;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && !(Z0 && (r_s2Da == '0))) begin
            r_regs[r_s2Da] <= w_busD;
        end
    end

    // Flags always reflect the ALU result, even for a memory load
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_v <= 1'b0;
            r_c <= 1'b0;
            r_n <= 1'b0;
            r_z <= 1'b0;
        end else if (w_commit && r_s2.fl) begin
            r_v <= w_aluV;
            r_c <= w_aluC;
            r_n <= w_aluN;
            r_z <= w_aluZ;
        end
    end

    assign bus.Adrout   = w_opA;
    assign bus.Dout     = w_opB;
    assign bus.V        = r_v;
    assign bus.C        = r_c;
    assign bus.N        = r_n;
    assign bus.Z        = r_z;
    assign bus.WB_VALID = r_s2.valid;
    assign bus.WB_DATA  = w_busD;

endmodule

// File: tb/tb_pipe_datapath.sv
// Scoreboard bench for pipe_datapath: a 16-bit instance and an 8-bit
// instance with register 0 hardwired to zero share one clock and reset.
module tb_pipe_datapath;

    typedef struct {
        logic [15:0] data;
        bit          chkF;
        logic [3:0]  flags;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_datapath_if #(.W(16), .NREG(8)) if16 ();
    pipe_datapath_if #(.W(8),  .NREG(8)) if8 ();

    pipe_datapath #(.W(16), .NREG(8), .ZERO_R0(0)) dut16 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (if16)
    );

    pipe_datapath #(.W(8), .NREG(8), .ZERO_R0(1)) dut8 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (if8)
    );

    exp_t        q16[$];
    exp_t        q8[$];
    int          nChecks = 0;
    int          nFail   = 0;
    int          nextId  = 0;
    bit          pend16  = 1'b0;
    bit          pend8   = 1'b0;
    logic [3:0]  pendF16;
    logic [3:0]  pendF8;
    int          pendId16;
    int          pendId8;

    task automatic checkOutput(input string name, input int id,
                               input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s#%0d: actual 0x%0h, required 0x%0h", name, id, act, exp);
        end
    endtask

    function automatic logic [16:0] cw(input int da, input int aa, input int ba,
                                       input bit mb, input logic [3:0] fs,
                                       input bit md, input bit rw, input bit fl);
        logic [2:0] d;
        logic [2:0] a;
        logic [2:0] b;
        d = da[2:0];
        a = aa[2:0];
        b = ba[2:0];
        return {d, a, b, mb, fs, md, rw, fl};
    endfunction

    // Drive one cycle of inputs; captured instructions get their expected writeback queued
    task automatic applyStimulus(input bit use8, input bit vin, input bit hold,
                                 input logic [16:0] cword, input logic [15:0] cin,
                                 input logic [15:0] din, input bit push,
                                 input logic [15:0] expData, input bit chkF,
                                 input logic [3:0] expF);
        exp_t e;
        @(posedge clk);
        #1;
        if (use8) begin
            if8.VIN    = vin;
            if8.HOLD   = hold;
            if8.CTRWRD = cword;
            if8.Cin    = cin[7:0];
            if8.Din    = din[7:0];
        end else begin
            if16.VIN    = vin;
            if16.HOLD   = hold;
            if16.CTRWRD = cword;
            if16.Cin    = cin;
            if16.Din    = din;
        end
        if (push && vin && !hold) begin
            e.data  = expData;
            e.chkF  = chkF;
            e.flags = expF;
            e.id    = nextId;
            nextId++;
            if (use8) q8.push_back(e);
            else      q16.push_back(e);
        end
    endtask

    // Retirement monitors: an instruction leaves stage 2 when valid and not held or reset
    always @(negedge clk) begin : mon16
        exp_t e;
        if (pend16) begin
            checkOutput("flags16", pendId16, {12'h0, if16.V, if16.C, if16.N, if16.Z}, {12'h0, pendF16});
            pend16 = 1'b0;
        end
        if (if16.WB_VALID && !if16.HOLD && !rst) begin
            if (q16.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpected_wb16: actual WB_DATA 0x%0h, required no retirement", if16.WB_DATA);
            end else begin
                e = q16.pop_front();
                checkOutput("wb16", e.id, if16.WB_DATA, e.data);
                if (e.chkF) begin
                    pend16   = 1'b1;
                    pendF16  = e.flags;
                    pendId16 = e.id;
                end
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (pend8) begin
            checkOutput("flags8", pendId8, {12'h0, if8.V, if8.C, if8.N, if8.Z}, {12'h0, pendF8});
            pend8 = 1'b0;
        end
        if (if8.WB_VALID && !if8.HOLD && !rst) begin
            if (q8.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpected_wb8: actual WB_DATA 0x%0h, required no retirement", if8.WB_DATA);
            end else begin
                e = q8.pop_front();
                checkOutput("wb8", e.id, {8'h0, if8.WB_DATA}, e.data);
                if (e.chkF) begin
                    pend8   = 1'b1;
                    pendF8  = e.flags;
                    pendId8 = e.id;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual still running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        if16.VIN    = 1'b0;
        if16.HOLD   = 1'b0;
        if16.CTRWRD = '0;
        if16.Cin    = '0;
        if16.Din    = '0;
        if8.VIN     = 1'b0;
        if8.HOLD    = 1'b0;
        if8.CTRWRD  = '0;
        if8.Cin     = '0;
        if8.Din     = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_wbvalid16", 0, {15'h0, if16.WB_VALID}, 16'h0);
        checkOutput("rst_wbdata16",  0, if16.WB_DATA, 16'h0);
        checkOutput("rst_flags16",   0, {12'h0, if16.V, if16.C, if16.N, if16.Z}, 16'h0);
        checkOutput("rst_wbvalid8",  0, {15'h0, if8.WB_VALID}, 16'h0);

        // 16-bit instance: overflow on 0x7FFF + 1
        applyStimulus(0, 1, 0, cw(1, 0, 0, 1, 4'b1100, 0, 1, 0), 16'h7FFF, 16'h0, 1, 16'h7FFF, 0, 4'h0);
        #1 checkOutput("dout_cin16", 0, if16.Dout, 16'h7FFF);
        applyStimulus(0, 1, 0, cw(2, 0, 0, 1, 4'b1100, 0, 1, 0), 16'h0001, 16'h0, 1, 16'h0001, 0, 4'h0);
        applyStimulus(0, 1, 0, cw(3, 1, 2, 0, 4'b0010, 0, 1, 1), 16'h0, 16'h0, 1, 16'h8000, 1, 4'b1010);

        // Back-to-back dependency through forwarding
        applyStimulus(0, 1, 0, cw(1, 0, 0, 1, 4'b1100, 0, 1, 0), 16'h0005, 16'h0, 1, 16'h0005, 1, 4'b1010);
        applyStimulus(0, 1, 0, cw(4, 1, 1, 0, 4'b0010, 0, 1, 0), 16'h0, 16'h0, 1, 16'h000A, 1, 4'b1010);
        #1 checkOutput("adrout_fwd16", 0, if16.Adrout, 16'h0005);
        checkOutput("dout_fwd16", 0, if16.Dout, 16'h0005);

        // Memory load, then a bubble that must not write
        applyStimulus(0, 1, 0, cw(5, 2, 0, 0, 4'b0000, 1, 1, 0), 16'h0, 16'h0, 1, 16'hBEEF, 1, 4'b1010);
        #1 checkOutput("adrout_load16", 0, if16.Adrout, 16'h0001);
        applyStimulus(0, 0, 0, cw(5, 0, 0, 1, 4'b1100, 0, 1, 0), 16'h1234, 16'hBEEF, 0, 16'h0, 0, 4'h0);
        #1 checkOutput("dout_bubble16", 0, if16.Dout, 16'h1234);
        applyStimulus(0, 1, 0, cw(0, 5, 0, 0, 4'b0000, 0, 0, 0), 16'h0, 16'h0, 1, 16'hBEEF, 1, 4'b1010);
        @(negedge clk);
        checkOutput("bubble_wbvalid16", 0, {15'h0, if16.WB_VALID}, 16'h0);

        // Increment held for three cycles must retire once
        applyStimulus(0, 1, 0, cw(6, 6, 0, 0, 4'b0001, 0, 1, 1), 16'h0, 16'h0, 1, 16'h0001, 1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, cw(0, 1, 0, 0, 4'b0000, 0, 0, 0), 16'h0, 16'h0, 0, 16'h0, 0, 4'h0);
            #1 checkOutput("adrout_hold16", i, if16.Adrout, 16'h0005);
        end
        applyStimulus(0, 1, 0, cw(0, 6, 0, 0, 4'b0000, 0, 0, 0), 16'h0, 16'h0, 1, 16'h0001, 1, 4'b0000);
        #1 checkOutput("adrout_heldfwd16", 0, if16.Adrout, 16'h0001);
        applyStimulus(0, 1, 0, cw(0, 6, 0, 0, 4'b0000, 0, 0, 0), 16'h0, 16'h0, 1, 16'h0001, 1, 4'b0000);

        // 10 - 5 carries out; then reset discards an in-flight write to R7
        applyStimulus(0, 1, 0, cw(3, 4, 1, 0, 4'b0101, 0, 1, 1), 16'h0, 16'h0, 1, 16'h0005, 1, 4'b0100);
        applyStimulus(0, 1, 0, cw(7, 0, 0, 1, 4'b1100, 0, 1, 1), 16'h8055, 16'h0, 0, 16'h0, 0, 4'h0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        if16.VIN = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_wbvalid16", 0, {15'h0, if16.WB_VALID}, 16'h0);
        checkOutput("midrst_wbdata16",  0, if16.WB_DATA, 16'h0);
        checkOutput("midrst_flags16",   0, {12'h0, if16.V, if16.C, if16.N, if16.Z}, 16'h0);
        applyStimulus(0, 1, 0, cw(0, 7, 0, 0, 4'b0000, 0, 0, 0), 16'h0, 16'h0, 1, 16'h0000, 1, 4'b0000);
        applyStimulus(0, 1, 0, cw(0, 1, 0, 0, 4'b0000, 0, 0, 0), 16'h0, 16'h0, 1, 16'h0000, 1, 4'b0000);
        applyStimulus(0, 0, 0, cw(0, 0, 0, 0, 4'b0000, 0, 0, 0), 16'h0, 16'h0, 0, 16'h0, 0, 4'h0);

        // 8-bit instance with register 0 tied to zero
        applyStimulus(1, 1, 0, cw(1, 1, 0, 0, 4'b0110, 0, 1, 1), 16'h0, 16'h0, 1, 16'h00FF, 1, 4'b0010);
        applyStimulus(1, 1, 0, cw(2, 0, 0, 1, 4'b1110, 0, 1, 1), 16'h0080, 16'h0, 1, 16'h0000, 1, 4'b0101);
        applyStimulus(1, 1, 0, cw(0, 0, 0, 1, 4'b1100, 0, 1, 0), 16'h005A, 16'h0, 1, 16'h005A, 1, 4'b0101);
        applyStimulus(1, 1, 0, cw(0, 0, 0, 0, 4'b0000, 0, 0, 0), 16'h0, 16'h0, 1, 16'h0000, 1, 4'b0101);
        #1 checkOutput("adrout_r0_8", 0, {8'h0, if8.Adrout}, 16'h0000);
        applyStimulus(1, 1, 0, cw(0, 0, 0, 0, 4'b1100, 0, 0, 0), 16'h0, 16'h0, 1, 16'h0000, 0, 4'h0);
        #1 checkOutput("dout_r0_8", 0, {8'h0, if8.Dout}, 16'h0000);
        applyStimulus(1, 1, 0, cw(3, 0, 1, 0, 4'b1101, 0, 1, 1), 16'h0, 16'h0, 1, 16'h007F, 1, 4'b0100);
        applyStimulus(1, 1, 0, cw(4, 1, 3, 0, 4'b1010, 0, 1, 1), 16'h0, 16'h0, 1, 16'h0080, 1, 4'b0010);
        #1 checkOutput("dout_fwd8", 0, {8'h0, if8.Dout}, 16'h007F);
        applyStimulus(1, 1, 0, cw(0, 4, 0, 0, 4'b0000, 0, 0, 0), 16'h0, 16'h0, 1, 16'h0080, 1, 4'b0010);
        applyStimulus(1, 0, 0, cw(0, 0, 0, 0, 4'b0000, 0, 0, 0), 16'h0, 16'h0, 0, 16'h0, 0, 4'h0);

        for (int i = 0; i < 10; i++) begin
            if (q16.size() == 0 && q8.size() == 0 && !pend16 && !pend8) break;
            @(negedge clk);
        end
        @(posedge clk);
        checkOutput("drain16", 0, 16'(q16.size()), 16'h0);
        checkOutput("drain8",  0, 16'(q8.size()),  16'h0);
        checkOutput("drainflags", 0, {14'h0, pend16, pend8}, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
